// File: rtl/flash_burst_reader_pkg.sv
// Shared types for the parallel NOR flash read path.
package flash_burst_reader_pkg;

    localparam int unsigned FLASH_ADDR_W = 23;

    typedef logic [FLASH_ADDR_W-1:0] Flash_addr_t;
    typedef logic [15:0]             Halfword_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} FlashRdState_t;

    // Width of the beat field inside flash_a; a single-beat response has none.
    function automatic int unsigned beat_bits(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 0;
    endfunction

endpackage

// File: rtl/flash_burst_reader_if.sv
// Request/response channel between the bus bridge and the flash burst reader.
interface flash_rd_if #(
    parameter int unsigned BEATS = 2
);
    localparam int unsigned RSP_W = 16 * BEATS;

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             rsp_valid;
    logic [RSP_W-1:0] rsp_data;
    logic             busy;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/flash_burst_reader.sv
// Read-only NOR flash controller: assembles BEATS halfwords per request, each held for
// WAIT_CYCLES clocks with chip and output enable low.
module flash_burst_reader
    import flash_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned BEATS       = 2,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    flash_rd_if.slave         bus,
    output logic [ADDR_W-1:0] flash_a,
    inout  wire  [15:0]       flash_d,
    output logic              flash_rp_n,
    output logic              flash_vpen,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_byte_n
);

    localparam int unsigned RSP_W = 16 * BEATS;
    localparam int unsigned BW    = beat_bits(BEATS);
    localparam int unsigned BCW   = (BW > 0) ? BW : 1;
    localparam int unsigned WA_W  = ADDR_W - BW - 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    if (!(BEATS == 1 || BEATS == 2 || BEATS == 4)) begin : g_bad_beats
        $error("flash_burst_reader: BEATS must be 1, 2 or 4");
    end
    if (WAIT_CYCLES == 0) begin : g_bad_wait
        $error("flash_burst_reader: WAIT_CYCLES must be at least 1");
    end

    FlashRdState_t     state_q, state_d;
    logic [WA_W-1:0]   word_q, word_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RSP_W-1:0]  slot_q, slot_d;
    logic [RSP_W-1:0]  rsp_data_q, rsp_data_d;
    logic [RSP_W-1:0]  assembled;
    logic [ADDR_W-1:0] flash_a_q, flash_a_d, a_next;
    logic              ce_n_q, oe_n_q;
    Halfword_t         hw;
    logic              unused_addr;

    assign hw          = flash_d;
    assign unused_addr = ^{bus.req_addr[31:ADDR_W], bus.req_addr[BW:0]};

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        rsp_data_d = rsp_data_q;
        assembled  = slot_q;
        assembled[16 * int'(beat_q) +: 16] = hw;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = ACCESS;
                    word_d  = bus.req_addr[ADDR_W-1:BW+1];
                    beat_d  = '0;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                    cnt_d  = '0;
                    slot_d = assembled;
                    if (beat_q == BCW'(BEATS - 1)) begin
                        state_d    = RESP;
                        rsp_data_d = assembled;
                        beat_d     = '0;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat field sits between the word address and the byte-mode A0 bit.
    if (BW == 0) begin : g_a_single
        assign a_next = {word_d, 1'b0};
    end else begin : g_a_burst
        assign a_next = {word_d, beat_d[BW-1:0], 1'b0};
    end

    always_comb begin
        flash_a_d = '0;
        if (state_d == ACCESS) flash_a_d = a_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            rsp_data_q <= '0;
            flash_a_q  <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            rsp_data_q <= rsp_data_d;
            flash_a_q  <= flash_a_d;
            ce_n_q     <= (state_d != ACCESS);
            oe_n_q     <= (state_d != ACCESS);
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;

    assign flash_a      = flash_a_q;
    assign flash_ce_n   = ce_n_q;
    assign flash_oe_n   = oe_n_q;
    assign flash_rp_n   = 1'b1;
    assign flash_vpen   = 1'b0;
    assign flash_we_n   = 1'b1;
    assign flash_byte_n = 1'b1;

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench: default reader (BEATS=2, WAIT_CYCLES=3) and a wide fast one (BEATS=4, WAIT=1).
module tb_flash_burst_reader;
    import flash_burst_reader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    flash_rd_if #(.BEATS(2)) bus0 ();
    flash_rd_if #(.BEATS(4)) bus1 ();

    logic [22:0] a0, a1;
    wire  [15:0] d0, d1;
    logic rp0, vp0, ce0, oe0, we0, by0;
    logic rp1, vp1, ce1, oe1, we1, by1;

    flash_burst_reader #(.ADDR_W(23), .BEATS(2), .WAIT_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .flash_a(a0), .flash_d(d0), .flash_rp_n(rp0),
        .flash_vpen(vp0), .flash_ce_n(ce0), .flash_oe_n(oe0), .flash_we_n(we0),
        .flash_byte_n(by0)
    );

    flash_burst_reader #(.ADDR_W(23), .BEATS(4), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .flash_a(a1), .flash_d(d1), .flash_rp_n(rp1),
        .flash_vpen(vp1), .flash_ce_n(ce1), .flash_oe_n(oe1), .flash_we_n(we1),
        .flash_byte_n(by1)
    );

    // Flash model: data appears once the address has been stable WAIT-1 cycles with oe_n low.
    function automatic logic [15:0] fd(input logic [22:0] a);
        return a[16:1] ^ 16'hA5A5;
    endfunction

    int age0 = 0, age1 = 0;
    logic [22:0] la0 = '0, la1 = '0;
    logic loe0 = 1'b1, loe1 = 1'b1;

    always @(negedge clk) begin
        if (!oe0 && !loe0 && a0 == la0) age0 = age0 + 1; else age0 = 0;
        if (!oe1 && !loe1 && a1 == la1) age1 = age1 + 1; else age1 = 0;
        la0 = a0; loe0 = oe0;
        la1 = a1; loe1 = oe1;
    end

    assign d0 = oe0 ? 16'hzzzz : ((a0 == la0 && oe0 == loe0 && age0 >= 2) ? fd(a0) : 16'hxxxx);
    assign d1 = oe1 ? 16'hzzzz : ((a1 == la1 && oe1 == loe1 && age1 >= 0) ? fd(a1) : 16'hxxxx);

    logic [22:0] pa0 = '0, pa1 = '0;
    logic poe0 = 1'b1, poe1 = 1'b1;
    int run0 = 0, run1 = 0;

    // Advance one cycle, sample mid-cycle and check the pin invariants and beat stability.
    task automatic step();
        @(negedge clk);
        #1;
        n_vec++;
        if (we0 !== 1'b1 || we1 !== 1'b1 || rp0 !== 1'b1 || rp1 !== 1'b1 || vp0 !== 1'b0 ||
            vp1 !== 1'b0 || by0 !== 1'b1 || by1 !== 1'b1 || a0[0] !== 1'b0 || a1[0] !== 1'b0 ||
            bus0.busy === bus0.req_ready || bus1.busy === bus1.req_ready) begin
            n_bad++;
            $display("FAIL pins: we=%b%b rp=%b%b vpen=%b%b byte=%b%b a0=%h a1=%h busy/ready=%b%b %b%b",
                     we0, we1, rp0, rp1, vp0, vp1, by0, by1, a0, a1, bus0.busy, bus0.req_ready,
                     bus1.busy, bus1.req_ready);
        end
        n_vec++;
        if ((!oe0 && !poe0 && a0 !== pa0 && run0 != 3) ||
            (!oe1 && !poe1 && a1 !== pa1 && run1 != 1)) begin
            n_bad++;
            $display("FAIL beat_hold: run0=%0d run1=%0d, required 3 and 1", run0, run1);
        end
        run0 = oe0 ? 0 : ((!poe0 && a0 == pa0) ? run0 + 1 : 1);
        run1 = oe1 ? 0 : ((!poe1 && a1 == pa1) ? run1 + 1 : 1);
        pa0 = a0; poe0 = oe0;
        pa1 = a1; poe1 = oe1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_vec++;
        if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_data !== 32'h0 ||
            bus0.busy !== 1'b0 || ce0 !== 1'b1 || oe0 !== 1'b1 || a0 !== 23'h0) begin
            n_bad++;
            $display("FAIL reset0: ready=%b rv=%b data=%h busy=%b ce=%b oe=%b a=%h",
                     bus0.req_ready, bus0.rsp_valid, bus0.rsp_data, bus0.busy, ce0, oe0, a0);
        end
        n_vec++;
        if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0 || bus1.rsp_data !== 64'h0 ||
            bus1.busy !== 1'b0 || ce1 !== 1'b1 || oe1 !== 1'b1 || a1 !== 23'h0) begin
            n_bad++;
            $display("FAIL reset1: ready=%b rv=%b data=%h busy=%b ce=%b oe=%b a=%h",
                     bus1.req_ready, bus1.rsp_valid, bus1.rsp_data, bus1.busy, ce1, oe1, a1);
        end
        rst = 1'b0;
        step();
    endtask

    // One request on the default reader; n counts cycles with the accept cycle as 1.
    task automatic do_read0(input logic [31:0] addr, input logic [22:0] exp_a,
                            input logic [31:0] exp_d, input string name);
        int n;
        bus0.req_valid = 1'b1;
        bus0.req_addr  = addr;
        step();
        bus0.req_valid = 1'b0;
        bus0.req_addr  = 32'hFFFF_FFFF;
        n = 1;
        n_vec++;
        if (a0 !== exp_a || ce0 !== 1'b0 || oe0 !== 1'b0 || bus0.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s beat0: a=%h ce=%b oe=%b ready=%b, required a=%h ce=0 oe=0 ready=0",
                     name, a0, ce0, oe0, bus0.req_ready, exp_a);
        end
        while (!bus0.rsp_valid && n < 20) begin
            step();
            n++;
            if (n == 4) begin
                n_vec++;
                if (a0 !== exp_a + 23'd2) begin
                    n_bad++;
                    $display("FAIL %s beat1: a=%h required %h", name, a0, exp_a + 23'd2);
                end
            end
        end
        n_vec++;
        if (n != 7) begin
            n_bad++;
            $display("FAIL %s latency: rsp in cycle %0d, required 7", name, n);
        end
        n_vec++;
        if (bus0.rsp_data !== exp_d || ce0 !== 1'b1 || oe0 !== 1'b1 || a0 !== 23'h0) begin
            n_bad++;
            $display("FAIL %s rsp: data=%h ce=%b oe=%b a=%h, required data=%h ce=1 oe=1 a=0",
                     name, bus0.rsp_data, ce0, oe0, a0, exp_d);
        end
        step();
        n_vec++;
        if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1 || bus0.rsp_data !== exp_d) begin
            n_bad++;
            $display("FAIL %s after: rv=%b ready=%b data=%h, required rv=0 ready=1 data=%h",
                     name, bus0.rsp_valid, bus0.req_ready, bus0.rsp_data, exp_d);
        end
    endtask

    task automatic test_single();
        do_read0(32'h0000_0010, 23'h10, 32'hA5AC_A5AD, "single");
    endtask

    task automatic test_addr_bounds();
        do_read0(32'h0000_0013, 23'h10, 32'hA5AC_A5AD, "low_bits");
        do_read0(32'h00FF_FFFC, 23'h7F_FFFC, 32'h5A5A_5A5B, "top_addr");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp [3];
        int acc [3];
        int k, r, t, idle_rsp;
        bit pend;
        addrs = '{32'h0000_0100, 32'h0000_0204, 32'h0000_03F8};
        exp   = '{32'hA524_A525, 32'hA4A6_A4A7, 32'hA458_A459};
        acc   = '{0, 0, 0};
        k = 0; r = 0; t = 0; pend = 1'b0;
        bus0.req_valid = 1'b1;
        bus0.req_addr  = addrs[0];
        while (r < 3 && t < 60) begin
            if (bus0.req_valid && bus0.req_ready) begin
                acc[k] = t;
                k++;
                pend = 1'b1;
            end
            step();
            t++;
            if (pend) begin
                pend = 1'b0;
                if (k < 3) bus0.req_addr = addrs[k];
                else bus0.req_valid = 1'b0;
            end
            if (bus0.rsp_valid) begin
                n_vec++;
                if (bus0.rsp_data !== exp[r]) begin
                    n_bad++;
                    $display("FAIL b2b rsp%0d: data=%h required %h", r, bus0.rsp_data, exp[r]);
                end
                r++;
            end
        end
        n_vec++;
        if (k != 3 || r != 3) begin
            n_bad++;
            $display("FAIL b2b count: accepts=%0d responses=%0d, required 3 and 3", k, r);
        end
        n_vec++;
        if (acc[1] - acc[0] != 8 || acc[2] - acc[1] != 8) begin
            n_bad++;
            $display("FAIL b2b spacing: %0d %0d, required 8 8", acc[1] - acc[0], acc[2] - acc[1]);
        end
        idle_rsp = 0;
        repeat (10) begin
            step();
            if (bus0.rsp_valid || bus0.busy) idle_rsp++;
        end
        n_vec++;
        if (idle_rsp != 0) begin
            n_bad++;
            $display("FAIL b2b extra: %0d busy/rsp cycles after drain, required 0", idle_rsp);
        end
    endtask

    task automatic test_wide();
        logic [22:0] exp_a [4];
        int n, ce_lo;
        exp_a = '{23'h40, 23'h42, 23'h44, 23'h46};
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 32'h0000_0040;
        step();
        bus1.req_valid = 1'b0;
        n = 1;
        ce_lo = 0;
        while (!bus1.rsp_valid && n < 20) begin
            if (n <= 4) begin
                n_vec++;
                if (a1 !== exp_a[n-1]) begin
                    n_bad++;
                    $display("FAIL wide beat%0d: a=%h required %h", n - 1, a1, exp_a[n-1]);
                end
            end
            if (!ce1) ce_lo++;
            step();
            n++;
        end
        n_vec++;
        if (n != 5 || ce_lo != 4 || ce1 !== 1'b1) begin
            n_bad++;
            $display("FAIL wide timing: rsp cycle %0d ce_low %0d ce=%b, required 5 4 1", n, ce_lo, ce1);
        end
        n_vec++;
        if (bus1.rsp_data !== 64'hA586_A587_A584_A585) begin
            n_bad++;
            $display("FAIL wide data: %h required a586a587a584a585", bus1.rsp_data);
        end
        step();
        n_vec++;
        if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wide after: rv=%b ready=%b, required 0 1", bus1.rsp_valid, bus1.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus0.req_valid = 1'b1;
        bus0.req_addr  = 32'h0000_0020;
        step();
        bus0.req_valid = 1'b0;
        repeat (4) step();
        n_vec++;
        if (a0 !== 23'h22 || oe0 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid pre: a=%h oe=%b, required 22 0", a0, oe0);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (ce0 !== 1'b1 || oe0 !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.busy !== 1'b0 ||
            bus0.req_ready !== 1'b1 || a0 !== 23'h0 || bus0.rsp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid: ce=%b oe=%b rv=%b busy=%b ready=%b a=%h data=%h",
                     ce0, oe0, bus0.rsp_valid, bus0.busy, bus0.req_ready, a0, bus0.rsp_data);
        end
        step();
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            step();
            if (bus0.rsp_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_mid rsp: %0d rsp_valid cycles after abort, required 0", seen);
        end
        do_read0(32'h0000_0010, 23'h10, 32'hA5AC_A5AD, "post_rst");
    endtask

    initial begin
        bus0.req_valid = 1'b0;
        bus0.req_addr  = '0;
        bus1.req_valid = 1'b0;
        bus1.req_addr  = '0;
        test_reset();
        test_single();
        test_addr_bounds();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
